// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, DMA and Data_Memory signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_stall_o;

    logic              dma_req_i;
    logic              dma_we_i;
    logic [ADDR_W-1:0] dma_addr_i;
    logic [3:0]        dma_len_i;
    logic [DATA_W-1:0] dma_wdata_i;
    logic [DATA_W-1:0] dma_rdata_o;
    logic              dma_beat_o;
    logic              dma_busy_o;
    logic              dma_done_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        input  dma_req_i, dma_we_i, dma_addr_i, dma_len_i, dma_wdata_i,
        output dma_rdata_o, dma_beat_o, dma_busy_o, dma_done_o,
        output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
        input  mem_rdata_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        output dma_req_i, dma_we_i, dma_addr_i, dma_len_i, dma_wdata_i,
        input  dma_rdata_o, dma_beat_o, dma_busy_o, dma_done_o,
        input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage and a burst DMA engine.
// The CPU wins in IDLE; during a burst it is granted only once its wait reaches STARVE_LIMIT.
module dmem_arbiter #(
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic            clk_i,
    input logic            rst_i,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic {S_IDLE, S_BURST} state_e;

    localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        rem_q, rem_d;
    logic              we_q, we_d;
    logic [3:0]        wait_q, wait_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cpu_grant, dma_grant, starve, cpu_stall;
    logic [ADDR_W-1:0] dma_addr_cur;
    logic              dma_we_cur;
    logic [3:0]        start_rem;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        starve    = bus.cpu_req_i && (wait_q == LIMIT);
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        case (state_q)
            S_IDLE: begin
                cpu_grant = bus.cpu_req_i;
                dma_grant = bus.dma_req_i & ~bus.cpu_req_i;
            end
            S_BURST: begin
                cpu_grant = starve;
                dma_grant = ~starve;
            end
            default: ;
        endcase
        cpu_stall = bus.cpu_req_i & ~cpu_grant;

        // Beat 1 runs straight from the request inputs; later beats use the latched copy.
        dma_addr_cur = (state_q == S_IDLE) ? bus.dma_addr_i : addr_q;
        dma_we_cur   = (state_q == S_IDLE) ? bus.dma_we_i   : we_q;

        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_read_o  = 1'b0;
        bus.mem_write_o = 1'b0;
        if (cpu_grant) begin
            bus.mem_addr_o  = bus.cpu_addr_i;
            bus.mem_wdata_o = bus.cpu_wdata_i;
            bus.mem_read_o  = ~bus.cpu_we_i;
            bus.mem_write_o = bus.cpu_we_i;
        end else if (dma_grant) begin
            bus.mem_addr_o  = dma_addr_cur;
            bus.mem_wdata_o = bus.dma_wdata_i;
            bus.mem_read_o  = ~dma_we_cur;
            bus.mem_write_o = dma_we_cur;
        end
    end

    // A length code of 0 means 16 beats, so 4-bit wraparound of len-1 gives 15 remaining.
    assign start_rem = bus.dma_len_i - 4'd1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wait_d  = cpu_stall ? wait_q + 4'd1 : 4'd0;
        case (state_q)
            S_IDLE: begin
                if (dma_grant) begin
                    addr_d = bus.dma_addr_i + WORD_STEP;
                    rem_d  = start_rem;
                    we_d   = bus.dma_we_i;
                    if (start_rem != 4'd0) begin
                        state_d = S_BURST;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (dma_grant) begin
                    addr_d = addr_q + WORD_STEP;
                    rem_d  = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.cpu_stall_o = cpu_stall;
    assign bus.cpu_rdata_o = bus.mem_rdata_i;
    assign bus.dma_rdata_o = bus.mem_rdata_i;
    assign bus.dma_beat_o  = dma_grant;
    assign bus.dma_busy_o  = busy_q;
    assign bus.dma_done_o  = done_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: CPU access, DMA bursts, priority, starvation, reset abort, wrap.
// Inputs change just after the falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Data_Memory model: combinational read, write at the rising edge; word i preloads to A000_0000+i.
    logic [31:0] mem [0:255];
    assign bus.mem_rdata_i = mem[bus.mem_addr_o[9:2]];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (bus.mem_write_o) begin
            mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata);
        bus.cpu_req_i   = req;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
    endtask

    task automatic drive_dma(input logic req, input logic we, input logic [31:0] addr,
                             input logic [3:0] len, input logic [31:0] wdata);
        bus.dma_req_i   = req;
        bus.dma_we_i    = we;
        bus.dma_addr_i  = addr;
        bus.dma_len_i   = len;
        bus.dma_wdata_i = wdata;
    endtask

    logic        exp_stall, exp_beat;
    int          beat_n;

    initial begin
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_dma(1'b0, 1'b0, 32'h0, 4'd0, 32'h0);

        // Reset state
        @(negedge clk); #1;
        check("rst_busy",  bus.dma_busy_o, 1'b0);
        check("rst_done",  bus.dma_done_o, 1'b0);
        check("rst_stall", bus.cpu_stall_o, 1'b0);
        check("rst_mread", bus.mem_read_o, 1'b0);
        @(negedge clk); rst = 1'b0;

        // CPU write then read at 0x10
        drive_cpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF); #1;
        check("cpu_wr_stall", bus.cpu_stall_o, 1'b0);
        check("cpu_wr_mwrite", bus.mem_write_o, 1'b1);
        check("cpu_wr_addr", bus.mem_addr_o, 32'h10);
        check("cpu_wr_data", bus.mem_wdata_o, 32'hDEADBEEF);
        @(negedge clk); drive_cpu(1'b1, 1'b0, 32'h10, 32'h0); #1;
        check("cpu_rd_stall", bus.cpu_stall_o, 1'b0);
        check("cpu_rd_mread", bus.mem_read_o, 1'b1);
        check("cpu_rd_data", bus.cpu_rdata_o, 32'hDEADBEEF);
        @(negedge clk); drive_cpu(1'b0, 1'b0, 32'h0, 32'h0); #1;
        check("idle_mread", bus.mem_read_o, 1'b0);
        check("idle_addr", bus.mem_addr_o, 32'h0);

        // DMA write burst, len 4 at 0x40, data 1..4
        @(negedge clk); drive_dma(1'b1, 1'b1, 32'h40, 4'd4, 32'd1); #1;
        check("dw_b1_beat", bus.dma_beat_o, 1'b1);
        check("dw_b1_addr", bus.mem_addr_o, 32'h40);
        check("dw_b1_write", bus.mem_write_o, 1'b1);
        check("dw_b1_busy", bus.dma_busy_o, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk); drive_dma(1'b0, 1'b0, 32'h0, 4'd0, k); #1;
            check("dw_beat", bus.dma_beat_o, 1'b1);
            check("dw_addr", bus.mem_addr_o, 32'h40 + 4 * (k - 1));
            check("dw_wdata", bus.mem_wdata_o, k);
            check("dw_write", bus.mem_write_o, 1'b1);
            check("dw_busy", bus.dma_busy_o, 1'b1);
            check("dw_nodone", bus.dma_done_o, 1'b0);
        end
        @(negedge clk); drive_dma(1'b0, 1'b0, 32'h0, 4'd0, 32'h0); #1;
        check("dw_done", bus.dma_done_o, 1'b1);
        check("dw_busy_off", bus.dma_busy_o, 1'b0);
        check("dw_beat_off", bus.dma_beat_o, 1'b0);
        @(negedge clk); drive_cpu(1'b1, 1'b0, 32'h4C, 32'h0); #1;
        check("dw_done_pulse", bus.dma_done_o, 1'b0);
        check("dw_readback", bus.cpu_rdata_o, 32'd4);

        // Simultaneous requests in IDLE: CPU first, DMA (len 1 read at 0x80) next cycle
        @(negedge clk); drive_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        drive_dma(1'b1, 1'b0, 32'h80, 4'd1, 32'h0); #1;
        check("pri_stall", bus.cpu_stall_o, 1'b0);
        check("pri_beat", bus.dma_beat_o, 1'b0);
        check("pri_addr", bus.mem_addr_o, 32'h10);
        @(negedge clk); drive_cpu(1'b0, 1'b0, 32'h0, 32'h0); #1;
        check("pri_dma_beat", bus.dma_beat_o, 1'b1);
        check("pri_dma_addr", bus.mem_addr_o, 32'h80);
        check("pri_dma_rdata", bus.dma_rdata_o, 32'hA000_0020);
        @(negedge clk); drive_dma(1'b0, 1'b0, 32'h0, 4'd0, 32'h0); #1;
        check("len1_done", bus.dma_done_o, 1'b1);
        check("len1_busy", bus.dma_busy_o, 1'b0);

        // Starvation: 16-beat read at 0x80, CPU reads 0x10 during cycles 2..6
        @(negedge clk); drive_dma(1'b1, 1'b0, 32'h80, 4'd0, 32'h0); #1;
        check("st_b1_addr", bus.mem_addr_o, 32'h80);
        check("st_b1_beat", bus.dma_beat_o, 1'b1);
        for (int c = 2; c <= 17; c++) begin
            @(negedge clk);
            drive_dma(1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
            drive_cpu(c <= 6, 1'b0, 32'h10, 32'h0); #1;
            exp_stall = (c >= 2) && (c <= 5);
            exp_beat  = (c != 6);
            beat_n    = (c <= 5) ? c : c - 1;
            check("st_stall", bus.cpu_stall_o, exp_stall);
            check("st_beat", bus.dma_beat_o, exp_beat);
            check("st_busy", bus.dma_busy_o, 1'b1);
            if (exp_beat) begin
                check("st_dma_addr", bus.mem_addr_o, 32'h80 + 4 * (beat_n - 1));
                check("st_dma_rdata", bus.dma_rdata_o, 32'hA000_0020 + beat_n - 1);
            end else begin
                check("st_cpu_addr", bus.mem_addr_o, 32'h10);
                check("st_cpu_rdata", bus.cpu_rdata_o, 32'hDEADBEEF);
            end
        end
        @(negedge clk); #1;
        check("st_done", bus.dma_done_o, 1'b1);
        check("st_busy_off", bus.dma_busy_o, 1'b0);

        // Reset after beat 3 of an 8-beat write at 0xC0, then a fresh burst at 0x100
        @(negedge clk); drive_dma(1'b1, 1'b1, 32'hC0, 4'd8, 32'h11); #1;
        check("ra_b1_addr", bus.mem_addr_o, 32'hC0);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk); drive_dma(1'b0, 1'b0, 32'h0, 4'd0, 32'h11 * k); #1;
            check("ra_addr", bus.mem_addr_o, 32'hC0 + 4 * (k - 1));
            check("ra_write", bus.mem_write_o, 1'b1);
        end
        @(negedge clk); rst = 1'b1; #1;
        check("ra_rst_write", bus.mem_write_o, 1'b0);
        check("ra_rst_busy", bus.dma_busy_o, 1'b0);
        check("ra_rst_beat", bus.dma_beat_o, 1'b0);
        @(negedge clk); rst = 1'b0; #1;
        check("ra_nodone", bus.dma_done_o, 1'b0);
        check("ra_nobeat", bus.dma_beat_o, 1'b0);
        @(negedge clk); #1;
        check("ra_nodone2", bus.dma_done_o, 1'b0);
        @(negedge clk); drive_dma(1'b1, 1'b1, 32'h100, 4'd2, 32'h55); #1;
        check("rb_b1_addr", bus.mem_addr_o, 32'h100);
        check("rb_b1_beat", bus.dma_beat_o, 1'b1);
        @(negedge clk); drive_dma(1'b0, 1'b0, 32'h0, 4'd0, 32'h66); #1;
        check("rb_b2_addr", bus.mem_addr_o, 32'h104);
        check("rb_b2_busy", bus.dma_busy_o, 1'b1);
        @(negedge clk); drive_dma(1'b0, 1'b0, 32'h0, 4'd0, 32'h0); #1;
        check("rb_done", bus.dma_done_o, 1'b1);

        // Wrap: len 2 read at 0xFFFFFFFC, back-to-back len 1 at 0x20 in the done cycle
        @(negedge clk); drive_dma(1'b1, 1'b0, 32'hFFFF_FFFC, 4'd2, 32'h0); #1;
        check("wr_b1_addr", bus.mem_addr_o, 32'hFFFF_FFFC);
        check("wr_b1_rdata", bus.dma_rdata_o, 32'hA000_00FF);
        @(negedge clk); drive_dma(1'b0, 1'b0, 32'h0, 4'd0, 32'h0); #1;
        check("wr_b2_addr", bus.mem_addr_o, 32'h0);
        check("wr_b2_rdata", bus.dma_rdata_o, 32'hA000_0000);
        check("wr_b2_busy", bus.dma_busy_o, 1'b1);
        @(negedge clk); drive_dma(1'b1, 1'b0, 32'h20, 4'd1, 32'h0); #1;
        check("wr_done", bus.dma_done_o, 1'b1);
        check("b2b_beat", bus.dma_beat_o, 1'b1);
        check("b2b_addr", bus.mem_addr_o, 32'h20);
        check("b2b_busy", bus.dma_busy_o, 1'b0);
        @(negedge clk); drive_dma(1'b0, 1'b0, 32'h0, 4'd0, 32'h0); #1;
        check("b2b_done", bus.dma_done_o, 1'b1);
        check("b2b_idle", bus.dma_beat_o, 1'b0);
        @(negedge clk); #1;
        check("b2b_done_off", bus.dma_done_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and burst sequencer for the single-port data memory used by the pipelined CPU. It sits between the MEM stage (requester 0) and a word-burst DMA/loader engine (requester 1) on one side, and the Data_Memory on the other. It stalls the pipeline whenever the memory is owned by a burst. A starvation counter bounds how long the CPU can be held off.

## Interface
Parameters:
- ADDR_W, 32, address width, byte addresses; word aligned
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive stalled CPU cycles tolerated during a burst; must be 1..15

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- cpu_req_i  in  1  MEM stage requests access this cycle (MemRead | MemWrite)
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  ADDR_W  CPU byte address
- cpu_wdata_i  in  DATA_W  CPU write data
- cpu_rdata_o  out  DATA_W  read data, valid when cpu_req_i & ~cpu_stall_o
- cpu_stall_o  out  1  CPU not granted this cycle; pipeline freezes
- dma_req_i  in  1  start a burst; sampled only in IDLE
- dma_we_i  in  1  burst direction; latched at start
- dma_addr_i  in  ADDR_W  burst start address; latched at start
- dma_len_i  in  4  beats; 0 means 16; latched at start
- dma_wdata_i  in  DATA_W  write data for the current beat
- dma_rdata_o  out  DATA_W  read data, valid when dma_beat_o = 1
- dma_beat_o  out  1  one beat executed this cycle
- dma_busy_o  out  1  burst in progress (registered)
- dma_done_o  out  1  one-cycle pulse, the cycle after the last beat
- mem_addr_o  out  ADDR_W  to Data_Memory
- mem_wdata_o  out  DATA_W  to Data_Memory
- mem_read_o  out  1  to Data_Memory MemRead
- mem_write_o  out  1  to Data_Memory MemWrite
- mem_rdata_i  in  DATA_W  Data_Memory read data; combinational, same cycle

## Operation
States:
- **IDLE**
  - cpu_req_i = 1: CPU is granted. cpu_req_i has priority over dma_req_i.
  - dma_req_i = 1 and cpu_req_i = 0: DMA is granted. Beat 1 runs this cycle at dma_addr_i.
    - Latch the next address: dma_addr_i + 4.
    - Latch remaining = len − 1, where len = 16 if dma_len_i = 0.
    - Latch dma_we_i.
  - Go to BURST if remaining > 0. Otherwise pulse done and stay in IDLE.
- **BURST**
  - Each cycle the DMA is granted:
    - One beat at the latched address.
    - Address += 4, wrapping mod 2^ADDR_W.
    - remaining −= 1.
  - When remaining = 0 after a beat: go to IDLE and pulse done next cycle.
  - dma_req_i is ignored.
- **Starvation**
  - wait_cnt (4 bit) increments each cycle with cpu_req_i & cpu_stall_o.
  - It clears on any CPU grant or when cpu_req_i = 0.
  - In BURST, if wait_cnt == STARVE_LIMIT and cpu_req_i = 1, the CPU is granted that cycle.
    - The DMA pauses: dma_beat_o = 0, address and remaining hold.
- **Grant datapath** (combinational)
  - mem_* follow the granted requester.
  - No grant: mem_read_o = mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - mem_read_o = grant & ~we; mem_write_o = grant & we.
  - cpu_rdata_o and dma_rdata_o both = mem_rdata_i.
- cpu_stall_o = cpu_req_i & ~cpu_grant. Never asserted when cpu_req_i = 0.
- dma_busy_o: 1 from the edge after beat 1 through the edge after the last beat. It is 0 for len = 1.

## Timing
- Reset values: state IDLE, dma_busy_o 0, dma_done_o 0, wait_cnt 0, latched address and remaining 0.
- Combinational outputs in IDLE after reset:
  - cpu_stall_o = 0.
  - dma_beat_o = dma_req_i & ~cpu_req_i.
- Reset mid-burst: burst aborts immediately, with no done pulse and no further beats.
- Latency:
  - CPU access completes in its request cycle when granted; write commits at that edge.
  - A burst of N beats without contention takes N consecutive cycles.
  - dma_done_o is at cycle N+1.
- Back-to-back bursts: dma_req_i held high in the done cycle starts the next burst in that same cycle (state is IDLE).
- Contention in BURST with STARVE_LIMIT = L: the CPU is stalled L cycles and granted on cycle L+1. Each CPU grant delays the burst by one cycle.
- Write data: dma_wdata_i must be valid in every cycle with dma_beat_o = 1. The source advances to the next word only after dma_beat_o.
- Address wrap: 0xFFFFFFFC + 4 → 0x00000000 with no error.

## Test plan
- CPU only: write 0x10 ← 0xDEADBEEF, then read 0x10 → cpu_rdata_o = 0xDEADBEEF, cpu_stall_o = 0 throughout.
- DMA write burst, len 4, addr 0x40, data 1..4 → writes at 0x40/44/48/4C on 4 consecutive cycles; dma_done_o at cycle 5; dma_busy_o high cycles 2–4.
- Simultaneous cpu_req_i and dma_req_i in IDLE → CPU granted, dma_beat_o = 0; DMA starts the next cycle once cpu_req_i drops.
- Starvation: DMA read burst len 0 (16 beats), CPU read asserted from burst cycle 2 → stall for cycles 2–5, CPU granted cycle 6; 16 beats complete by cycle 17, done at cycle 18 (cpu_req_i dropped after grant).
- Reset asserted after beat 3 of an 8-beat burst → mem_write_o = 0 immediately, busy 0, no done; a new burst at 0x100 restarts from 0x100.
- Wrap: len 2 at 0xFFFFFFFC → beats at 0xFFFFFFFC then 0x00000000; done after beat 2.
